// File: rtl/vm_param_if.sv
// Bundles the front-panel strobes and the display/coin-return outputs of the
// vending-machine core. The master side is the stimulus/front-panel block; the
// slave side is the vm_param core.
interface vm_param_if #(
    parameter int N_PROD = 4,
    parameter int VAL_W  = 8
);
    logic              escolher;
    logic [7:0]        produto_escolhido;
    logic              inserir_dinheiro;
    logic [VAL_W-1:0]  dinheiro_inserido;
    logic              dar_troco;
    logic              restock;

    logic [7:0]        produto_vendido;
    logic              vend_valid;
    logic [VAL_W-1:0]  carteira;
    logic [VAL_W-1:0]  valor_troco;
    logic              coin_out_valid;
    logic [VAL_W-1:0]  coin_out_value;
    logic              coin_reject;
    logic [3:0]        dinheiro_inserido_c;
    logic [3:0]        dinheiro_inserido_d;
    logic [3:0]        dinheiro_inserido_u;
    logic [N_PROD-1:0] sold_out;
    logic              busy;
    logic [1:0]        err_code;

    modport master (
        output escolher, produto_escolhido, inserir_dinheiro, dinheiro_inserido,
               dar_troco, restock,
        input  produto_vendido, vend_valid, carteira, valor_troco, coin_out_valid,
               coin_out_value, coin_reject, dinheiro_inserido_c, dinheiro_inserido_d,
               dinheiro_inserido_u, sold_out, busy, err_code
    );

    modport slave (
        input  escolher, produto_escolhido, inserir_dinheiro, dinheiro_inserido,
               dar_troco, restock,
        output produto_vendido, vend_valid, carteira, valor_troco, coin_out_valid,
               coin_out_value, coin_reject, dinheiro_inserido_c, dinheiro_inserido_d,
               dinheiro_inserido_u, sold_out, busy, err_code
    );
endinterface

// File: rtl/vm_param.sv
// Parametrised vending-machine core: credit accumulation, per-product price and
// stock, and greedy coin-by-coin change dispensing.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | accepting coins, selections, refunds and restock
//   CHANGE | paying out carteira one coin per cycle (25/10/5/1); inputs ignored
module vm_param #(
    parameter int                          N_PROD     = 4,
    parameter int                          VAL_W      = 8,
    parameter int                          STOCK_W    = 4,
    parameter int                          STOCK_INIT = 5,
    parameter logic [N_PROD*VAL_W-1:0]     PRICES     = {8'd50, 8'd35, 8'd25, 8'd10}
) (
    input logic      clock,
    input logic      reset,
    vm_param_if.slave bus
);

    typedef enum logic {IDLE = 1'b0, CHANGE = 1'b1} state_t;

    localparam logic [VAL_W-1:0] COIN_25 = VAL_W'(25);
    localparam logic [VAL_W-1:0] COIN_10 = VAL_W'(10);
    localparam logic [VAL_W-1:0] COIN_5  = VAL_W'(5);
    localparam logic [VAL_W-1:0] COIN_1  = VAL_W'(1);
    localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_INIT);

    state_t state, state_nxt;

    logic [VAL_W-1:0]   carteira, carteira_nxt;
    logic [VAL_W-1:0]   valor_troco, valor_troco_nxt;
    logic [7:0]         produto_vendido, produto_vendido_nxt;
    logic               vend_valid, vend_valid_nxt;
    logic               coin_out_valid, coin_out_valid_nxt;
    logic [VAL_W-1:0]   coin_out_value, coin_out_value_nxt;
    logic               coin_reject, coin_reject_nxt;
    logic [1:0]         err_code, err_code_nxt;
    logic [3:0]         bcd_c, bcd_d, bcd_u;
    logic [3:0]         bcd_c_nxt, bcd_d_nxt, bcd_u_nxt;
    logic [STOCK_W-1:0] stock     [N_PROD];
    logic [STOCK_W-1:0] stock_nxt [N_PROD];
    logic [N_PROD-1:0]  sold_out;

    logic               id_valid;
    logic [N_PROD-1:0]  id_hit;
    logic [VAL_W-1:0]   sel_price;
    logic [STOCK_W-1:0] sel_stock;
    logic [VAL_W-1:0]   remainder;
    logic [VAL_W:0]     coin_sum;
    logic [VAL_W-1:0]   change_coin;
    logic               sale;
    int unsigned        disp_val;

    // Look up the selected product's price and stock; out-of-range ids hit nothing.
    always_comb begin
        id_valid  = int'(bus.produto_escolhido) < N_PROD;
        id_hit    = '0;
        sel_price = '0;
        sel_stock = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (int'(bus.produto_escolhido) == i) begin
                id_hit[i] = 1'b1;
                sel_price = PRICES[i*VAL_W +: VAL_W];
                sel_stock = stock[i];
            end
        end
        remainder = carteira - sel_price;
        // One extra bit catches credit overflow without wrapping.
        coin_sum  = {1'b0, carteira} + {1'b0, bus.dinheiro_inserido};
        sale      = (state == IDLE) && !bus.dar_troco && bus.escolher && id_valid &&
                    (sel_stock != '0) && (sel_price <= carteira);
    end

    // Greedy pick of the largest coin not exceeding the remaining credit.
    always_comb begin
        if (carteira >= COIN_25)      change_coin = COIN_25;
        else if (carteira >= COIN_10) change_coin = COIN_10;
        else if (carteira >= COIN_5)  change_coin = COIN_5;
        else                          change_coin = COIN_1;
    end

    // Next-state and next-output decode for the IDLE/CHANGE machine.
    always_comb begin
        state_nxt           = state;
        carteira_nxt        = carteira;
        valor_troco_nxt     = valor_troco;
        produto_vendido_nxt = produto_vendido;
        vend_valid_nxt      = 1'b0;
        coin_out_valid_nxt  = 1'b0;
        coin_out_value_nxt  = '0;
        coin_reject_nxt     = 1'b0;
        err_code_nxt        = 2'd0;
        stock_nxt           = stock;

        case (state)
            IDLE: begin
                if (bus.dar_troco) begin
                    coin_reject_nxt = bus.inserir_dinheiro;
                    if (carteira != '0) begin
                        valor_troco_nxt = carteira;
                        state_nxt       = CHANGE;
                    end
                end else if (bus.escolher) begin
                    coin_reject_nxt = bus.inserir_dinheiro;
                    if (!id_valid)                 err_code_nxt = 2'd1;
                    else if (sel_stock == '0)      err_code_nxt = 2'd2;
                    else if (sel_price > carteira) err_code_nxt = 2'd3;
                    else begin
                        vend_valid_nxt      = 1'b1;
                        produto_vendido_nxt = bus.produto_escolhido;
                        carteira_nxt        = remainder;
                        if (remainder != '0) begin
                            valor_troco_nxt = remainder;
                            state_nxt       = CHANGE;
                        end
                    end
                end else if (bus.inserir_dinheiro && bus.dinheiro_inserido != '0) begin
                    if (coin_sum[VAL_W]) coin_reject_nxt = 1'b1;
                    else                 carteira_nxt    = coin_sum[VAL_W-1:0];
                end

                // A same-edge restock overrides the sale's stock decrement.
                for (int i = 0; i < N_PROD; i++) begin
                    if (bus.restock)            stock_nxt[i] = STOCK_FULL;
                    else if (sale && id_hit[i]) stock_nxt[i] = stock[i] - 1'b1;
                end
            end

            CHANGE: begin
                coin_out_valid_nxt = 1'b1;
                coin_out_value_nxt = change_coin;
                carteira_nxt       = carteira - change_coin;
                coin_reject_nxt    = bus.inserir_dinheiro;
                if (carteira == change_coin) state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    // Display digits for the current credit, clamped to what three digits can show.
    always_comb begin
        disp_val = 32'(carteira);
        if (disp_val > 32'd999) disp_val = 32'd999;
        bcd_c_nxt = 4'(disp_val / 32'd100);
        bcd_d_nxt = 4'((disp_val / 32'd10) % 32'd10);
        bcd_u_nxt = 4'(disp_val % 32'd10);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            carteira        <= '0;
            valor_troco     <= '0;
            produto_vendido <= '0;
            vend_valid      <= 1'b0;
            coin_out_valid  <= 1'b0;
            coin_out_value  <= '0;
            coin_reject     <= 1'b0;
            err_code        <= 2'd0;
            bcd_c           <= '0;
            bcd_d           <= '0;
            bcd_u           <= '0;
            for (int i = 0; i < N_PROD; i++) stock[i] <= STOCK_FULL;
        end else begin
            carteira        <= carteira_nxt;
            valor_troco     <= valor_troco_nxt;
            produto_vendido <= produto_vendido_nxt;
            vend_valid      <= vend_valid_nxt;
            coin_out_valid  <= coin_out_valid_nxt;
            coin_out_value  <= coin_out_value_nxt;
            coin_reject     <= coin_reject_nxt;
            err_code        <= err_code_nxt;
            bcd_c           <= bcd_c_nxt;
            bcd_d           <= bcd_d_nxt;
            bcd_u           <= bcd_u_nxt;
            for (int i = 0; i < N_PROD; i++) stock[i] <= stock_nxt[i];
        end
    end

    // Sold-out flags follow the stock registers directly.
    always_comb begin
        for (int i = 0; i < N_PROD; i++) sold_out[i] = (stock[i] == '0);
    end

    assign bus.produto_vendido     = produto_vendido;
    assign bus.vend_valid          = vend_valid;
    assign bus.carteira            = carteira;
    assign bus.valor_troco         = valor_troco;
    assign bus.coin_out_valid      = coin_out_valid;
    assign bus.coin_out_value      = coin_out_value;
    assign bus.coin_reject         = coin_reject;
    assign bus.dinheiro_inserido_c = bcd_c;
    assign bus.dinheiro_inserido_d = bcd_d;
    assign bus.dinheiro_inserido_u = bcd_u;
    assign bus.sold_out            = sold_out;
    assign bus.busy                = (state != IDLE);
    assign bus.err_code            = err_code;

endmodule

// File: tb/tb_vm_param.sv
// Directed bench for vm_param: hand-computed expectations for sales, errors,
// change payout, stock depletion/restock, overflow rejection and reset.
module tb_vm_param;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   ncoins;

    vm_param_if #(.N_PROD(4), .VAL_W(8)) bus ();

    vm_param dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.escolher          = 1'b0;
        bus.produto_escolhido = 8'd0;
        bus.inserir_dinheiro  = 1'b0;
        bus.dinheiro_inserido = 8'd0;
        bus.dar_troco         = 1'b0;
        bus.restock           = 1'b0;
    endtask

    task automatic coin(input logic [7:0] v);
        bus.inserir_dinheiro  = 1'b1;
        bus.dinheiro_inserido = v;
        tick();
        idle_inputs();
    endtask

    task automatic sel(input logic [7:0] id);
        bus.escolher          = 1'b1;
        bus.produto_escolhido = id;
        tick();
        idle_inputs();
    endtask

    task automatic refund();
        bus.dar_troco = 1'b1;
        tick();
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_carteira", 32'(bus.carteira), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_sold_out", 32'(bus.sold_out), 0);
        chk("rst_vend", 32'(bus.vend_valid), 0);
        chk("rst_coin", 32'(bus.coin_out_valid), 0);
        chk("rst_bcd", 32'({bus.dinheiro_inserido_c, bus.dinheiro_inserido_d, bus.dinheiro_inserido_u}), 0);
        reset = 1'b0;
        tick();

        // No credit: selecting the 10-unit product is refused.
        sel(8'd0);
        chk("err_no_credit", 32'(bus.err_code), 3);
        chk("no_vend", 32'(bus.vend_valid), 0);
        tick();
        chk("err_pulse_end", 32'(bus.err_code), 0);

        // Zero-value coin is ignored.
        coin(8'd0);
        chk("zero_coin_cart", 32'(bus.carteira), 0);
        chk("zero_coin_rej", 32'(bus.coin_reject), 0);

        // 25 + 25, then buy product 2 (35) -> change 15 as 10 then 5.
        coin(8'd25);
        chk("cart_25", 32'(bus.carteira), 25);
        coin(8'd25);
        chk("cart_50", 32'(bus.carteira), 50);
        chk("bcd_lag", 32'({bus.dinheiro_inserido_c, bus.dinheiro_inserido_d, bus.dinheiro_inserido_u}), 32'h025);
        tick();
        chk("bcd_50", 32'({bus.dinheiro_inserido_c, bus.dinheiro_inserido_d, bus.dinheiro_inserido_u}), 32'h050);
        sel(8'd2);
        chk("sale2_vend", 32'(bus.vend_valid), 1);
        chk("sale2_id", 32'(bus.produto_vendido), 2);
        chk("sale2_troco", 32'(bus.valor_troco), 15);
        chk("sale2_busy", 32'(bus.busy), 1);
        tick();
        chk("chg1_valid", 32'(bus.coin_out_valid), 1);
        chk("chg1_value", 32'(bus.coin_out_value), 10);
        chk("chg1_vend_end", 32'(bus.vend_valid), 0);
        chk("chg1_busy", 32'(bus.busy), 1);
        tick();
        chk("chg2_value", 32'(bus.coin_out_value), 5);
        chk("chg2_cart", 32'(bus.carteira), 0);
        chk("chg2_busy", 32'(bus.busy), 0);
        tick();
        chk("chg_done", 32'(bus.coin_out_valid), 0);

        // Credit 10 is not enough for product 3 (50); refund pays one 10.
        coin(8'd10);
        sel(8'd3);
        chk("err_insuff", 32'(bus.err_code), 3);
        chk("insuff_cart", 32'(bus.carteira), 10);
        refund();
        chk("refund_troco", 32'(bus.valor_troco), 10);
        chk("refund_busy", 32'(bus.busy), 1);
        tick();
        chk("refund_coin", 32'(bus.coin_out_value), 10);
        chk("refund_idle", 32'(bus.busy), 0);

        // Drain product 0 with five exact sales.
        for (int k = 0; k < 5; k++) begin
            coin(8'd10);
            sel(8'd0);
            chk("exact_vend", 32'(bus.vend_valid), 1);
            chk("exact_busy", 32'(bus.busy), 0);
            chk("sold_out_k", 32'(bus.sold_out), (k == 4) ? 1 : 0);
        end
        coin(8'd10);
        sel(8'd0);
        chk("err_sold_out", 32'(bus.err_code), 2);
        chk("sold_out_cart", 32'(bus.carteira), 10);
        bus.restock = 1'b1;
        tick();
        idle_inputs();
        chk("restock", 32'(bus.sold_out), 0);
        refund();
        tick();
        chk("refund2_cart", 32'(bus.carteira), 0);

        // Invalid id.
        sel(8'd7);
        chk("err_bad_id", 32'(bus.err_code), 1);

        // Fill to 250, then an overflowing coin is returned.
        for (int k = 0; k < 10; k++) coin(8'd25);
        chk("cart_250", 32'(bus.carteira), 250);
        coin(8'd10);
        chk("ovf_reject", 32'(bus.coin_reject), 1);
        chk("ovf_cart", 32'(bus.carteira), 250);
        tick();
        chk("bcd_250", 32'({bus.dinheiro_inserido_c, bus.dinheiro_inserido_d, bus.dinheiro_inserido_u}), 32'h250);

        // Refund 250 as ten 25s; a coin inserted during payout is rejected.
        refund();
        bus.inserir_dinheiro  = 1'b1;
        bus.dinheiro_inserido = 8'd10;
        tick();
        idle_inputs();
        chk("chg_reject", 32'(bus.coin_reject), 1);
        chk("chg_coin25", 32'(bus.coin_out_value), 25);
        chk("chg_cart225", 32'(bus.carteira), 225);
        ncoins = 0;
        for (int k = 0; k < 20 && bus.busy; k++) begin
            tick();
            if (bus.coin_out_valid) ncoins++;
        end
        chk("chg_rest_coins", 32'(ncoins), 9);
        chk("chg_rest_busy", 32'(bus.busy), 0);
        chk("chg_rest_cart", 32'(bus.carteira), 0);

        // Select plus coin on the same edge: sale on old credit, coin returned.
        coin(8'd25);
        bus.escolher          = 1'b1;
        bus.produto_escolhido = 8'd1;
        bus.inserir_dinheiro  = 1'b1;
        bus.dinheiro_inserido = 8'd10;
        tick();
        idle_inputs();
        chk("combo_vend", 32'(bus.vend_valid), 1);
        chk("combo_id", 32'(bus.produto_vendido), 1);
        chk("combo_reject", 32'(bus.coin_reject), 1);
        chk("combo_cart", 32'(bus.carteira), 0);

        // Reset in the middle of a 40-unit payout.
        coin(8'd25);
        coin(8'd25);
        sel(8'd0);
        chk("r40_troco", 32'(bus.valor_troco), 40);
        tick();
        chk("r40_coin", 32'(bus.coin_out_value), 25);
        chk("r40_cart", 32'(bus.carteira), 15);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r40_no_coin", 32'(bus.coin_out_valid), 0);
        chk("r40_cart0", 32'(bus.carteira), 0);
        chk("r40_busy", 32'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
